instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Fetch stage directly upstream of the instruction cache. Generates sequential PCs, issues one
//  req/gnt/rvalid transaction at a time on the cached_instr_* interface, and buffers returned
//  instructions with their PCs in a small FIFO for decode. Accepts branch redirects from execute,
//  flushes the buffer and discards responses already in flight.
// PARAMETERS
//  DEPTH_LOG  2             log2 of FIFO depth (4 entries of {pc,instr})
//  RESET_PC   32'h0000_0000 first fetch address after reset; bits [1:0] must be 0
// PORTS
//  clk                  in   1   clock, rising edge
//  res                  in   1   reset, synchronous, active-low (res==0 resets)
//  cached_instr_req     out  1   request to cache
//  cached_instr_adr     out  32  fetch address, word aligned
//  cached_instr_gnt     in   1   cache accepted request
//  cached_instr_rvalid  in   1   cached_instr_read valid this cycle
//  cached_instr_read    in   32  returned instruction word
//  fetch_valid          out  1   fetch_instr/fetch_pc hold a valid instruction
//  fetch_instr          out  32  instruction at FIFO head
//  fetch_pc             out  32  PC of fetch_instr
//  fetch_ready          in   1   decode consumes head when fetch_valid&&fetch_ready
//  branch_taken         in   1   one-cycle redirect pulse
//  branch_target        in   32  redirect PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset: req=0, adr=RESET_PC, fetch_valid=0, fetch_instr=0, fetch_pc=RESET_PC, FIFO empty,
//   state=IDLE, drop flag=0. Reset mid-transaction abandons it; the cache is reset in the same cycle.
//  Slot rule: issue only if fifo_count + outstanding < 2**DEPTH_LOG; one outstanding max.
//  FSM: IDLE -> REQ when slot free and no redirect this cycle.
//   REQ: req=1, adr held; gnt -> WAIT_RVALID.
//   WAIT_RVALID: req=0, adr held stable (cache indexes/fills from adr until rvalid).
//    On rvalid -> IDLE; push {adr,read} unless drop flag set. Then pc<=pc+4, wraps FFFF_FFFC->0.
//  Redirect (branch_taken): FIFO cleared the same cycle; pc<=branch_target&~3.
//   In IDLE: next request uses the new pc. A same-cycle pop is ignored.
//   In REQ or WAIT_RVALID: the cache has committed the request, so adr stays on the old address.
//    Set drop flag; the response is discarded on rvalid; next request uses the redirect PC.
//   Same cycle as rvalid: response discarded, drop flag not set.
//   Second redirect while drop flag set: latest target wins.
//  Push and pop in the same cycle with the FIFO full: legal, because the slot rule reserved the entry.
//  Fetch latency without bypass: fetch_valid rises the cycle after rvalid.
//  Ordering: instructions leave in PC-sequence order between redirects; none duplicated or lost.
// CONFIGURATION
//  FETCH_BYPASS_EN defined:
//   FIFO empty and accepted rvalid -> fetch_valid=1 the same cycle.
//   fetch_instr=cached_instr_read, fetch_pc=adr.
//   Popped that cycle: not written to the FIFO. Not popped: written.
//  FETCH_BYPASS_EN undefined:
//   All outputs come from FIFO registers.
//   No combinational path from cached_instr_* to fetch_*.
// STRUCTURE
//  Package riscv_fetch_pkg: state encodings IDLE/REQ/WAIT_RVALID (one-hot, 3b),
//   PC_STEP=4, entry width 64 ({pc,instr}).
//  Sub-module prefetch_fifo:
//   Synchronous FIFO of {pc,instr}, parameter DEPTH_LOG.
//   Ports push/pop/flush/count; flush has priority over push.
//  Top level: FSM, pc register, drop flag, slot check, optional bypass mux.
// TESTING
//  1. Reset release, cache always hits (gnt 1 cycle after req, rvalid next):
//     adr 0,4,8,C issued in order; fetch_pc/instr match 0,4,8,C.
//  2. fetch_ready=0 for 20 cycles: exactly 4 entries buffered, req stays 0.
//     Then ready=1: 4 pops, fetching resumes at 0x10.
//  3. branch_taken to 0x103 while in WAIT_RVALID on 0x8: 0x8 response dropped, FIFO empty;
//     next adr=0x100, first fetch_pc=0x100.
//  4. branch_taken coincident with rvalid: that word never appears; next adr=target.
//  5. Miss latency: gnt delayed 7 cycles, rvalid 5 after gnt: adr stable whole window, req=0 after gnt.
//  6. RESET_PC=0xFFFF_FFFC: sequence FFFF_FFFC then 0.
//     Res pulsed low mid-REQ: outputs return to reset values next edge.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// Shared types for the instruction prefetch stage: FSM encoding, FIFO entry layout, PC helpers.
package riscv_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'b001,
    ST_REQ         = 3'b010,
    ST_WAIT_RVALID = 3'b100
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int unsigned ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO of {pc,instr} entries; flush overrides push and pop in the same cycle.
module prefetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned  DEPTH_LOG   = 2,
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic               clk,
  input  logic               res,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       rdata,
  output logic [DEPTH_LOG:0] count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(DEPTH);

  fetch_entry_t         mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_ENTRY;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Fetch stage ahead of the instruction cache: sequential PCs, one outstanding req/gnt/rvalid
// transaction, {pc,instr} buffer for decode, branch redirect with in-flight drop. Option: FETCH_BYPASS_EN.
module instr_prefetch
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        res,
  output logic        cached_instr_req,
  output logic [31:0] cached_instr_adr,
  input  logic        cached_instr_gnt,
  input  logic        cached_instr_rvalid,
  input  logic [31:0] cached_instr_read,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  fetch_state_e       state;
  fetch_state_e       state_nxt;
  logic [31:0]        pc;
  logic [31:0]        adr_q;
  logic               drop;
  logic [DEPTH_LOG:0] fifo_count;
  fetch_entry_t       head;
  fetch_entry_t       rsp_entry;
  logic               outstanding;
  logic               slot_free;
  logic               rsp_done;
  logic               rsp_accept;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;

  assign outstanding = (state != ST_IDLE);
  assign slot_free   = ({1'b0, fifo_count} + (DEPTH_LOG + 2)'(outstanding))
                       < (DEPTH_LOG + 2)'(DEPTH);
  assign rsp_done    = (state == ST_WAIT_RVALID) && cached_instr_rvalid;
  assign rsp_accept  = rsp_done && !drop && !branch_taken;
  assign fifo_empty  = (fifo_count == '0);
  assign rsp_entry   = '{pc: adr_q, instr: cached_instr_read};

  assign cached_instr_adr = adr_q;

  always_comb begin
    state_nxt        = state;
    cached_instr_req = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot_free && !branch_taken) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        cached_instr_req = 1'b1;
        if (cached_instr_gnt) state_nxt = ST_WAIT_RVALID;
      end
      ST_WAIT_RVALID: begin
        if (cached_instr_rvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      adr_q <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && (state_nxt == ST_REQ)) begin
        adr_q <= pc;
      end
      // The cache keeps indexing from adr_q after a redirect, so only pc moves.
      if (branch_taken) begin
        pc <= align_pc(branch_target);
      end else if (rsp_accept) begin
        pc <= adr_q + PC_STEP;
      end
      if (rsp_done) begin
        drop <= 1'b0;
      end else if (branch_taken && outstanding) begin
        drop <= 1'b1;
      end
    end
  end

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass      = fifo_empty && rsp_accept;
  assign fetch_valid = !fifo_empty || bypass;
  assign fetch_instr = bypass ? cached_instr_read : head.instr;
  assign fetch_pc    = bypass ? adr_q : head.pc;
  assign fifo_push   = rsp_accept && !(bypass && fetch_ready);
  assign fifo_pop    = !fifo_empty && fetch_ready && !branch_taken;
`else
  assign fetch_valid = !fifo_empty;
  assign fetch_instr = head.instr;
  assign fetch_pc    = head.pc;
  assign fifo_push   = rsp_accept;
  assign fifo_pop    = fetch_valid && fetch_ready && !branch_taken;
`endif

  prefetch_fifo #(
    .DEPTH_LOG   (DEPTH_LOG),
    .RESET_ENTRY (fetch_entry_t'{pc: RESET_PC, instr: 32'h0})
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (branch_taken),
    .wdata (rsp_entry),
    .rdata (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: directed address/fetch sequences against a scripted cache.
module tb_instr_prefetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        cached_instr_req;
  logic [31:0] cached_instr_adr;
  logic        cached_instr_gnt    = 1'b0;
  logic        cached_instr_rvalid = 1'b0;
  logic [31:0] cached_instr_read   = '0;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready   = 1'b0;
  logic        branch_taken  = 1'b0;
  logic [31:0] branch_target = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_adr[$];
  logic [31:0] exp_fetch[$];

  // Cache model control and state
  int          gd = 0;
  int          rd = 1;
  int          grants_left = 0;
  int          cst = 0;
  int          cnt = 0;
  int          rcnt = 0;
  logic [31:0] gadr = '0;
  logic        nxt_gnt = 1'b0;
  logic        nxt_rv = 1'b0;

  instr_prefetch #(
    .DEPTH_LOG (2),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk                 (clk),
    .res                 (res),
    .cached_instr_req    (cached_instr_req),
    .cached_instr_adr    (cached_instr_adr),
    .cached_instr_gnt    (cached_instr_gnt),
    .cached_instr_rvalid (cached_instr_rvalid),
    .cached_instr_read   (cached_instr_read),
    .fetch_valid         (fetch_valid),
    .fetch_instr         (fetch_instr),
    .fetch_pc            (fetch_pc),
    .fetch_ready         (fetch_ready),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Drives at negedge+1, samples at negedge+3, so samples see the inputs of the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cached_instr_gnt    = nxt_gnt;
      cached_instr_rvalid = nxt_rv;
      cached_instr_read   = nxt_rv ? instr_of(gadr) : 32'h0;
      #2;
      nxt_gnt = 1'b0;
      nxt_rv  = 1'b0;
      if (!res) begin
        cst = 0;
      end else begin
        case (cst)
          0: if (cached_instr_req && grants_left > 0) begin
            grants_left--;
            gadr = cached_instr_adr;
            if (exp_adr.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL req_adr: unexpected request at %h, required none", cached_instr_adr);
            end else begin
              chk("req_adr", cached_instr_adr, exp_adr.pop_front());
            end
            cnt = gd;
            if (cnt == 0) begin nxt_gnt = 1'b1; cst = 2; end
            else cst = 1;
          end
          1: begin
            chk("req_held", {31'b0, cached_instr_req}, 32'd1);
            chk("adr_stable_req", cached_instr_adr, gadr);
            cnt--;
            if (cnt == 0) begin nxt_gnt = 1'b1; cst = 2; end
          end
          2: begin
            chk("req_at_gnt", {31'b0, cached_instr_req}, 32'd1);
            rcnt = rd - 1;
            if (rcnt == 0) begin nxt_rv = 1'b1; cst = 3; end
            else cst = 4;
          end
          4: begin
            chk("req_low_wait", {31'b0, cached_instr_req}, 32'd0);
            chk("adr_stable_wait", cached_instr_adr, gadr);
            rcnt--;
            if (rcnt == 0) begin nxt_rv = 1'b1; cst = 3; end
          end
          3: begin
            chk("req_low_rvalid", {31'b0, cached_instr_req}, 32'd0);
            chk("adr_stable_rvalid", cached_instr_adr, gadr);
            cst = 0;
          end
          default: cst = 0;
        endcase
      end
    end
  end

  // Fetch monitor: every consumed instruction is matched against the expected PC order.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (res && fetch_valid && fetch_ready && !branch_taken) begin
        if (exp_fetch.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_pc: unexpected instruction at pc %h, required none", fetch_pc);
        end else begin
          e = exp_fetch.pop_front();
          chk("fetch_pc", fetch_pc, e);
          chk("fetch_instr", fetch_instr, instr_of(e));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic expect_seq(input logic [31:0] adrs[$], input logic [31:0] fetches[$]);
    foreach (adrs[i]) exp_adr.push_back(adrs[i]);
    foreach (fetches[i]) exp_fetch.push_back(fetches[i]);
    grants_left = adrs.size();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_adr.size() != 0 || exp_fetch.size() != 0) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: %0d addresses and %0d fetches pending, required 0",
               nm, exp_adr.size(), exp_fetch.size());
      exp_adr.delete();
      exp_fetch.delete();
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req"}, {31'b0, cached_instr_req}, 32'd0);
    chk({nm, "_adr"}, cached_instr_adr, RST_PC);
    chk({nm, "_valid"}, {31'b0, fetch_valid}, 32'd0);
    chk({nm, "_instr"}, fetch_instr, 32'h0);
    chk({nm, "_pc"}, fetch_pc, RST_PC);
  endtask

  initial begin
    int n;
    res = 1'b0;
    repeat (3) step();
    chk_reset("reset");

    // Wrap from the top of the address space; cache hits with gnt and rvalid one cycle apart
    gd = 0; rd = 1;
    fetch_ready = 1'b1;
    expect_seq('{RST_PC, 32'h0, 32'h4, 32'h8}, '{RST_PC, 32'h0, 32'h4, 32'h8});
    res = 1'b1;
    drain("seq");

    // Stalled decode: four entries fill the buffer and requests stop
    fetch_ready = 1'b0;
    expect_seq('{32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20},
               '{32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20});
    repeat (40) step();
    chk("full_req", {31'b0, cached_instr_req}, 32'd0);
    chk("full_grants_left", grants_left, 32'd2);
    chk("full_valid", {31'b0, fetch_valid}, 32'd1);
    chk("full_head_pc", fetch_pc, 32'hC);
    fetch_ready = 1'b1;
    drain("full");

    // Redirect while waiting for rvalid on 0x2C: that word is dropped
    gd = 0; rd = 3;
    expect_seq('{32'h24, 32'h28, 32'h2C, 32'h100, 32'h104}, '{32'h24, 32'h28, 32'h100, 32'h104});
    n = 0;
    while (!(cst == 4 && gadr == 32'h2C) && n < 200) begin step(); n++; end
    chk("wait_branch_found", {31'b0, (cst == 4 && gadr == 32'h2C)}, 32'd1);
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    chk("flush_valid", {31'b0, fetch_valid}, 32'd0);
    drain("wait_branch");

    // Redirect in the same cycle as rvalid for 0x108
    gd = 0; rd = 2;
    expect_seq('{32'h108, 32'h200, 32'h204}, '{32'h200, 32'h204});
    n = 0;
    while (!(cst == 3 && gadr == 32'h108) && n < 200) begin step(); n++; end
    chk("rvalid_branch_found", {31'b0, (cst == 3 && gadr == 32'h108)}, 32'd1);
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    drain("rvalid_branch");

    // Long miss: address must stay put across the whole window
    gd = 7; rd = 5;
    expect_seq('{32'h208, 32'h20C}, '{32'h208, 32'h20C});
    drain("miss");

    // Reset while a request is pending and entries are buffered
    gd = 0; rd = 1;
    fetch_ready = 1'b0;
    expect_seq('{32'h210, 32'h214}, '{});
    n = 0;
    while (!(grants_left == 0 && cst == 0 && cached_instr_req) && n < 100) begin step(); n++; end
    chk("stuck_req", {31'b0, cached_instr_req}, 32'd1);
    chk("stuck_adr", cached_instr_adr, 32'h218);
    chk("stuck_valid", {31'b0, fetch_valid}, 32'd1);
    res = 1'b0;
    step();
    chk_reset("midreset");
    fetch_ready = 1'b1;
    expect_seq('{RST_PC, 32'h0}, '{RST_PC, 32'h0});
    res = 1'b1;
    drain("after_reset");

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
